shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
Sequential unsigned multiplier built around the team's ripple-carry adder stage. It is the downstream consumer of the adder. Each cycle it presents the accumulator and multiplicand to a WIDTH-bit add, then captures the sum and carry-out and shifts. It produces a 2*WIDTH product after a fixed WIDTH iterations, with valid/ready handshakes on input and output.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH; WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous reset, active-low; one clock; async assert, released synchronously by the integrator.
- in_valid  input  1  operand pair a/b is presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  registered result, unsigned.

Behaviour:
- Reset (rst_n=0, immediate, no clock needed):
  - state=IDLE; M, ACC, Q, count and product all cleared to 0.
  - in_ready=1, out_valid=0.
- Internal registers:
  - M[WIDTH] holds the multiplicand.
  - ACC[WIDTH] is the accumulator.
  - Q[WIDTH] holds the multiplier / low product.
  - C[1] is the adder carry-out.
  - count[$clog2(WIDTH+1)] tracks iterations.
- State machine: IDLE, CALC, DONE.
  - IDLE: in_ready=1.
    - On an edge with in_valid=1: M<=a, Q<=b, ACC<=0, count<=0, then go to CALC.
    - With in_valid=0: stay in IDLE.
  - CALC: in_ready=0, out_valid=0. Each edge:
    - {C,ACC'} = Q[0] ? ACC+M : {1'b0,ACC}, computed with full WIDTH+1 carry.
    - {ACC,Q} <= {C,ACC',Q} >> 1. The carry enters the ACC MSB, so no bit is lost.
    - count <= count+1.
    - On the edge where count==WIDTH-1: product <= the shifted {ACC,Q} value, then go to DONE.
  - DONE: out_valid=1.
    - On an edge with out_ready=1: go to IDLE.
    - Otherwise hold. product stays stable while out_valid=1.
- Latency:
  - Operands are accepted on edge E0.
  - out_valid goes high after edge E0+WIDTH (8 cycles at default).
  - There is no early termination. b=0 and b=1 still take WIDTH cycles.
- Throughput: at most one operation per WIDTH+2 cycles. A new accept requires a return to IDLE.
- Input and backpressure rules:
  - in_valid while in CALC or DONE is ignored and does not corrupt state.
  - a and b are sampled only at acceptance; changes afterwards have no effect.
  - out_ready while in IDLE or CALC is ignored.
  - out_ready held low keeps DONE and product indefinitely.
- Arithmetic: unsigned only. The result is exact for all inputs; the maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits, so there is no overflow flag.
- product persistence: the register holds the last result after DONE->IDLE, until the next completion or reset.
- Reset mid-operation (any state): immediate return to IDLE with all registers cleared. The interrupted result is never presented.

Test Plan:
- Reset, then a=0, b=0 accepted -> out_valid rises exactly 8 cycles later with product=0x0000; in_ready=0 throughout CALC.
- a=13, b=11 with out_ready=1 -> product=0x008F (143); DONE lasts one cycle; in_ready=1 on the following cycle.
- a=255, b=255 -> product=0xFE01 (65025); confirms carry-out propagation into the ACC MSB.
- a=86, b=107 with out_ready=0 for 5 cycles after out_valid -> product holds 0x23F2 (9202) all 5 cycles. During CALC, in_valid=1 with a=1, b=1 is presented and ignored.
- Back-to-back: 4*8 then 32*64 -> 0x0020 then 0x0800; the second operation is accepted only after the first is taken.
- rst_n pulsed low at cycle 4 of CALC -> out_valid=0, in_ready=1 and product=0 immediately; a subsequent 2*1 yields 0x0002.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-add multiplier.
// Each CALC cycle does a WIDTH-bit add of the accumulator and the
// multiplicand, keeps the carry-out, and shifts {carry,ACC,Q} right by one.
// The 2*WIDTH product is ready after exactly WIDTH iterations.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   a, b                - multiplicand, multiplier (unsigned, WIDTH bits)
//   out_valid/out_ready - result handshake (valid only in DONE)
//   product             - registered 2*WIDTH result, held until next completion
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Adder stage: carry-out lands in bit WIDTH so the shift can pull it into
  // the ACC MSB and no bit of the partial product is lost.
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;

  always_comb begin
    sum     = q_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {1'b0, acc_q};
    // {C,ACC',Q} >> 1, keeping the low 2*WIDTH bits.
    shifted = {sum, q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = shifted[2*WIDTH-1:WIDTH];
        q_d     = shifted[WIDTH-1:0];
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=8): hand-computed products,
// latency, handshake and reset behaviour.
module tb_shift_add_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE. Returns at posedge+1 of the
  // first cycle out_valid is seen (or after the cycle bound expires).
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp, input bit inject);
    int k;
    int bad;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);  // operands must not matter any more
    k = 0; bad = 0;
    while (!out_valid && k < 20) begin
      if (in_ready) bad++;
      if (inject && k == 2) begin in_valid = 1'b1; a = 8'd1; b = 8'd1; end
      if (inject && k == 4) in_valid = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(W));
    chk({tag, "_ready_calc"}, 32'(bad), 32'd0);
    chk({tag, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 0*0
    run_op("zero", 8'd0, 8'd0, 16'h0000, 1'b0);
    @(posedge clk); #1;

    // 13*11, DONE lasts one cycle with out_ready=1
    run_op("13x11", 8'd13, 8'd11, 16'h008F, 1'b0);
    @(posedge clk); #1;
    chk("13x11_done_1cyc", 32'(out_valid), 32'd0);
    chk("13x11_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("13x11_persist", 32'(product), 32'h008F);

    // 255*255, carry into ACC MSB
    run_op("255x255", 8'd255, 8'd255, 16'hFE01, 1'b0);
    @(posedge clk); #1;

    // 86*107 with backpressure and an ignored in_valid during CALC
    out_ready = 1'b0;
    run_op("86x107", 8'd86, 8'd107, 16'h23F2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("86x107_hold_valid", 32'(out_valid), 32'd1);
      chk("86x107_hold_prod", 32'(product), 32'h23F2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("86x107_released", 32'(out_valid), 32'd0);

    // back-to-back: second op waits for the first to be taken
    out_ready = 1'b0;
    run_op("4x8", 8'd4, 8'd8, 16'h0020, 1'b0);
    in_valid = 1'b1; a = 8'd32; b = 8'd64;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("b2b_blocked_ready", 32'(in_ready), 32'd0);
      chk("b2b_blocked_prod", 32'(product), 32'h0020);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    run_op("32x64", 8'd32, 8'd64, 16'h0800, 1'b0);
    @(posedge clk); #1;

    // reset in the middle of CALC
    in_valid = 1'b1; a = 8'd200; b = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_product", 32'(product), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("midrst_no_present", 32'(out_valid), 32'd0);
    run_op("2x1", 8'd2, 8'd1, 16'h0002, 1'b0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
